mac_seq_ctrl: RTL and testbench
===============================

// Module: mac_seq_ctrl
// PURPOSE
//  Initiator side of the MAC operand/accumulator interface. Accepts a job of LEN
//  operand pairs over a valid/ready stream and drives mac_a/mac_b/mac_clr_n into
//  the MAC. Reads back mac_acc, reduces it to OUT_W bits and returns it on a
//  valid/ready result port. Sits between the operand source and the MAC datapath.
// PARAMETERS
//  DATA_W  8   operand width; must match the MAC a/b width
//  ACC_W   26  MAC accumulator width; must match the MAC acc width
//  LEN_W   8   job length counter width; max job = 2**LEN_W-1 pairs
//  OUT_W   16  result width, signed
// PORTS
//  clk        in   1       clock, all state on rising edge
//  rst_n      in   1       async active-low reset
//  start      in   1       job request, sampled in IDLE only
//  len        in   LEN_W   pairs in job, sampled with start
//  busy       out  1       high in every state except IDLE
//  op_vld     in   1       operand pair valid
//  op_rdy     out  1       operand pair accepted when op_vld&op_rdy
//  op_a       in   DATA_W  operand a, unsigned
//  op_b       in   DATA_W  operand b, unsigned
//  mac_a      out  DATA_W  to MAC a, registered
//  mac_b      out  DATA_W  to MAC b, registered
//  mac_clr_n  out  1       to MAC clr_n, registered; 0 clears acc next edge
//  mac_acc    in   ACC_W   from MAC acc
//  res_vld    out  1       result valid, held until res_rdy
//  res_rdy    in   1       result consumer ready
//  res        out  OUT_W   job result, signed
//  sat        out  1       res was clipped; qualified by res_vld
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, mac_a=mac_b=0, mac_clr_n=0, op_rdy=0, res_vld=0,
//   res=0, sat=0, busy=0. MAC shares rst_n, so acc is 0 too.
//  MAC adds mac_a*mac_b to acc on every edge with mac_clr_n=1. mac_a/mac_b are
//   therefore 0 on every cycle without an accepted pair.
//  MAC sign-extends product bit 15. Pairs with product>=0x8000 accumulate as
//   negative. This block does not correct that.
//  FSM:
//   IDLE : mac_clr_n=0. start&&len!=0 -> cnt=len, RUN. len==0 drops start.
//   RUN  : mac_clr_n=1, op_rdy=1. Handshake -> mac_a/b=op_a/b next cycle,
//          cnt-=1; on cnt 1->0 go DRAIN. No handshake -> mac_a/b=0.
//   DRAIN: 2 cycles, mac_a/b=0, mac_clr_n=1. Last accepted pair is in acc after
//          the 1st edge. 2nd cycle registers reduce(mac_acc) into res/sat -> OUT.
//   OUT  : res_vld=1, mac_clr_n=0 (acc cleared). res_vld&res_rdy -> IDLE, res_vld=0.
//  op_rdy is registered and drops the cycle after the final handshake; no extra
//   pair is accepted.
//  Latency: last handshake edge -> res_vld high = 3 edges.
//  start while busy is ignored. res/sat stay stable while res_vld&!res_rdy.
//  Reset mid-job: immediate return to reset values. Partial job discarded.
// CONFIGURATION
//  MAC_SEQ_SAT_EN defined: reduce = signed saturate mac_acc to
//   [-2**(OUT_W-1), 2**(OUT_W-1)-1]; sat=1 when clipped.
//  Undefined: reduce = mac_acc[OUT_W-1:0] (wraps); sat tied 0.
// TESTING
//  1. len=3, pairs (2,3),(4,5),(1,1) back-to-back, res_rdy=1 -> res=27, sat=0;
//     res_vld 3 edges after last handshake.
//  2. Same job with op_vld low 2 cycles between pairs -> res=27; mac_a=mac_b=0
//     on gap cycles.
//  3. len=3, pairs (127,127)x3 -> acc=48387. SAT_EN: res=32767, sat=1.
//     Else: res=0xBD03, sat=0.
//  4. res_rdy low 5 cycles in OUT, start pulsed -> res stable, busy=1,
//     start ignored. res_rdy=1 -> IDLE next edge.
//  5. start with len=0 -> busy stays 0, no res_vld. Then len=1, (200,1) -> res=200.
//  6. rst_n low during RUN after 2 of 4 pairs -> all outputs at reset values.
//     Next job len=1 (3,3) -> res=9.

Source files
------------

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: initiator side of the MAC operand/accumulator interface.
// Takes a job of `len` operand pairs over a valid/ready stream, feeds the
// pairs into the MAC through registered mac_a/mac_b/mac_clr_n, waits for the
// accumulator to settle, reduces mac_acc to OUT_W bits and returns it on a
// valid/ready result port.
//
// Handshake semantics (both streams): a transfer happens on a rising edge
// where valid and ready are both high. The producer holds its payload and
// valid until that edge; ready is registered here and never depends
// combinationally on valid.
//
// Build option MAC_SEQ_SAT_EN:
//   defined   -> result is mac_acc signed-saturated to OUT_W bits, sat flags clipping
//   undefined -> result is mac_acc[OUT_W-1:0] (wraps), sat is always 0
//
// The MAC sign-extends product bit 15, so pairs whose product is >= 0x8000
// accumulate as negative numbers. That is MAC behaviour and is passed through
// unchanged here.
module mac_seq_ctrl #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 26,
  parameter int LEN_W  = 8,
  parameter int OUT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  input  logic              op_vld,
  output logic              op_rdy,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_b,
  output logic              mac_clr_n,
  input  logic [ACC_W-1:0]  mac_acc,
  output logic              res_vld,
  input  logic              res_rdy,
  output logic [OUT_W-1:0]  res,
  output logic              sat
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic                drain_q, drain_d;
  logic [DATA_W-1:0]   mac_a_q, mac_a_d;
  logic [DATA_W-1:0]   mac_b_q, mac_b_d;
  logic                mac_clr_n_q, mac_clr_n_d;
  logic                op_rdy_q, op_rdy_d;
  logic                res_vld_q, res_vld_d;
  logic [OUT_W-1:0]    res_q, res_d;
  logic                sat_q, sat_d;

  logic [OUT_W-1:0]    red_res;
  logic                red_sat;

`ifdef MAC_SEQ_SAT_EN
  // Largest and smallest OUT_W-bit signed values, widened to the accumulator.
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [ACC_W-1:0] acc_s;
  assign acc_s = signed'(mac_acc);

  // Signed saturation of the accumulator into the result range.
  always_comb begin
    red_res = mac_acc[OUT_W-1:0];
    red_sat = 1'b0;
    if (acc_s > SAT_MAX) begin
      red_res = {1'b0, {(OUT_W-1){1'b1}}};
      red_sat = 1'b1;
    end else if (acc_s < SAT_MIN) begin
      red_res = {1'b1, {(OUT_W-1){1'b0}}};
      red_sat = 1'b1;
    end
  end
`else
  // Plain truncation; the upper accumulator bits are intentionally dropped.
  logic unused_acc_hi;
  assign unused_acc_hi = ^mac_acc[ACC_W-1:OUT_W];
  assign red_res       = mac_acc[OUT_W-1:0];
  assign red_sat       = 1'b0;
`endif

  // Next-state and next-output logic for the job sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    drain_d     = drain_q;
    mac_a_d     = '0;
    mac_b_d     = '0;
    mac_clr_n_d = mac_clr_n_q;
    op_rdy_d    = op_rdy_q;
    res_vld_d   = res_vld_q;
    res_d       = res_q;
    sat_d       = sat_q;

    unique case (state_q)
      ST_IDLE: begin
        mac_clr_n_d = 1'b0;
        op_rdy_d    = 1'b0;
        // A zero-length request is simply dropped.
        if (start && (len != '0)) begin
          cnt_d       = len;
          state_d     = ST_RUN;
          mac_clr_n_d = 1'b1;
          op_rdy_d    = 1'b1;
        end
      end

      ST_RUN: begin
        mac_clr_n_d = 1'b1;
        if (op_vld && op_rdy_q) begin
          mac_a_d = op_a;
          mac_b_d = op_b;
          cnt_d   = cnt_q - LEN_W'(1);
          // Final pair: drop ready now so no extra pair slips in.
          if (cnt_q == LEN_W'(1)) begin
            state_d  = ST_DRAIN;
            op_rdy_d = 1'b0;
            drain_d  = 1'b0;
          end
        end
      end

      ST_DRAIN: begin
        mac_clr_n_d = 1'b1;
        if (!drain_q) begin
          // First edge moves the last pair into the accumulator.
          drain_d = 1'b1;
        end else begin
          // Accumulator now holds the full job; capture it.
          res_d       = red_res;
          sat_d       = red_sat;
          res_vld_d   = 1'b1;
          mac_clr_n_d = 1'b0;
          state_d     = ST_OUT;
        end
      end

      ST_OUT: begin
        mac_clr_n_d = 1'b0;
        if (res_rdy) begin
          res_vld_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        mac_clr_n_d = 1'b0;
        op_rdy_d    = 1'b0;
        res_vld_d   = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset returns everything to idle immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      drain_q     <= 1'b0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      mac_clr_n_q <= 1'b0;
      op_rdy_q    <= 1'b0;
      res_vld_q   <= 1'b0;
      res_q       <= '0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      drain_q     <= drain_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      mac_clr_n_q <= mac_clr_n_d;
      op_rdy_q    <= op_rdy_d;
      res_vld_q   <= res_vld_d;
      res_q       <= res_d;
      sat_q       <= sat_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign op_rdy    = op_rdy_q;
  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign mac_clr_n = mac_clr_n_q;
  assign res_vld   = res_vld_q;
  assign res       = res_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Testbench for mac_seq_ctrl. Contains a behavioural MAC so the sequencer
// has a real accumulator to drive, and a job-level reference that computes
// each expected result from the operand pairs with plain integer arithmetic.
module tb_mac_seq_ctrl;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 26;
  localparam int LEN_W  = 8;
  localparam int OUT_W  = 16;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic              busy;
  logic              op_vld;
  logic              op_rdy;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] mac_a;
  logic [DATA_W-1:0] mac_b;
  logic              mac_clr_n;
  logic [ACC_W-1:0]  mac_acc;
  logic              res_vld;
  logic              res_rdy;
  logic [OUT_W-1:0]  res;
  logic              sat;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [OUT_W-1:0] exp_q[$];
  logic             exp_sat_q[$];

  mac_seq_ctrl #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W), .OUT_W(OUT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy),
    .op_vld(op_vld), .op_rdy(op_rdy), .op_a(op_a), .op_b(op_b),
    .mac_a(mac_a), .mac_b(mac_b), .mac_clr_n(mac_clr_n), .mac_acc(mac_acc),
    .res_vld(res_vld), .res_rdy(res_rdy), .res(res), .sat(sat)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural MAC: 16-bit product, bit 15 sign-extended into the accumulator.
  logic [15:0] mac_prod;
  assign mac_prod = 16'(mac_a) * 16'(mac_b);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)          mac_acc <= '0;
    else if (!mac_clr_n) mac_acc <= '0;
    else                 mac_acc <= mac_acc + {{(ACC_W-16){mac_prod[15]}}, mac_prod};
  end

  // ---------------- reference ----------------
  function automatic longint pair_value(input int a, input int b);
    longint p;
    p = longint'(a) * longint'(b);
    if (p >= 32768) p = p - 65536;
    return p;
  endfunction

  function automatic logic [16:0] ref_reduce(input longint s);
    logic [63:0] sv;
    sv = s;
`ifdef MAC_SEQ_SAT_EN
    if (s > 32767)  return {1'b1, 16'h7fff};
    if (s < -32768) return {1'b1, 16'h8000};
`endif
    return {1'b0, sv[15:0]};
  endfunction

  // ---------------- drivers ----------------
  task automatic start_job(input int l);
    start = 1'b1;
    len   = LEN_W'(l);
    @(negedge clk);
    start = 1'b0;
    len   = '0;
  endtask

  // Present one pair, wait for the handshake edge; returns at the negedge after it.
  task automatic send_pair(input int a, input int b, output int hs_cyc);
    int n;
    n = 0;
    op_a   = DATA_W'(a);
    op_b   = DATA_W'(b);
    op_vld = 1'b1;
    while (!op_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_cmp++; n_err++;
      $display("FAIL op_rdy_timeout: op_rdy=%0b required=1", op_rdy);
    end
    @(negedge clk);
    hs_cyc = cyc;
    op_vld = 1'b0;
  endtask

  // Wait for res_vld, hold off res_rdy for rdy_delay cycles, then accept.
  task automatic get_result(input int rdy_delay, output logic [OUT_W-1:0] r,
                            output logic s, output int vld_cyc, output logic clr_seen);
    int n;
    n = 0;
    while (!res_vld && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_cmp++; n_err++;
      $display("FAIL res_vld_timeout: res_vld=%0b required=1", res_vld);
    end
    vld_cyc  = cyc;
    r        = res;
    s        = sat;
    clr_seen = mac_clr_n;
    repeat (rdy_delay) @(negedge clk);
    res_rdy = 1'b1;
    @(negedge clk);
    res_rdy = 1'b0;
  endtask

  // Full job with random pairs; pushes the expected result onto the scoreboard.
  task automatic run_job(input int l, input bit hi, input int max_gap, input int rdy_delay,
                         output logic [OUT_W-1:0] r, output logic s);
    longint sum;
    logic [16:0] e;
    int a, b, hs, vc;
    logic clr;
    sum = 0;
    start_job(l);
    for (int i = 0; i < l; i++) begin
      a = hi ? $urandom_range(180, 255) : $urandom_range(0, 255);
      b = hi ? $urandom_range(180, 255) : $urandom_range(0, 255);
      sum += pair_value(a, b);
      send_pair(a, b, hs);
      repeat ($urandom_range(0, max_gap)) @(negedge clk);
    end
    e = ref_reduce(sum);
    exp_q.push_back(e[15:0]);
    exp_sat_q.push_back(e[16]);
    get_result(rdy_delay, r, s, vc, clr);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; len = '0; op_vld = 1'b0;
    op_a = '0; op_b = '0; res_rdy = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, op_rdy, mac_clr_n, res_vld, sat} !== 5'b0 || mac_a !== '0 ||
        mac_b !== '0 || res !== '0) begin
      n_err++;
      $display("FAIL reset_values: busy=%0b op_rdy=%0b clr_n=%0b res_vld=%0b sat=%0b mac_a=%0d mac_b=%0d res=%0d required all 0",
               busy, op_rdy, mac_clr_n, res_vld, sat, mac_a, mac_b, res);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int hs, vc;
    logic [OUT_W-1:0] r;
    logic s, clr;
    start_job(3);
    n_cmp++;
    if (busy !== 1'b1 || op_rdy !== 1'b1 || mac_clr_n !== 1'b1) begin
      n_err++;
      $display("FAIL basic_run_entry: busy=%0b op_rdy=%0b clr_n=%0b required 1 1 1",
               busy, op_rdy, mac_clr_n);
    end
    send_pair(2, 3, hs);
    send_pair(4, 5, hs);
    send_pair(1, 1, hs);
    n_cmp++;
    if (op_rdy !== 1'b0) begin
      n_err++;
      $display("FAIL basic_rdy_drop: op_rdy=%0b required=0", op_rdy);
    end
    // Keep offering a junk pair: it must not be taken.
    op_a = 8'd99; op_b = 8'd99; op_vld = 1'b1;
    get_result(0, r, s, vc, clr);
    op_vld = 1'b0;
    n_cmp++;
    if (r !== 16'd27 || s !== 1'b0) begin
      n_err++;
      $display("FAIL basic_result: res=%0d sat=%0b required res=27 sat=0", r, s);
    end
    // Handshake edge plus two more edges.
    n_cmp++;
    if (vc - hs !== 2) begin
      n_err++;
      $display("FAIL basic_latency: edges_after_handshake=%0d required=2", vc - hs);
    end
    n_cmp++;
    if (clr !== 1'b0) begin
      n_err++;
      $display("FAIL basic_out_clr: mac_clr_n=%0b required=0", clr);
    end
    n_cmp++;
    if (busy !== 1'b0 || res_vld !== 1'b0) begin
      n_err++;
      $display("FAIL basic_idle_after: busy=%0b res_vld=%0b required 0 0", busy, res_vld);
    end
  endtask

  task automatic test_gaps();
    int hs, vc;
    int pa[3] = '{2, 4, 1};
    int pb[3] = '{3, 5, 1};
    logic [OUT_W-1:0] r;
    logic s, clr;
    start_job(3);
    for (int i = 0; i < 3; i++) begin
      send_pair(pa[i], pb[i], hs);
      n_cmp++;
      if (mac_a !== DATA_W'(pa[i]) || mac_b !== DATA_W'(pb[i])) begin
        n_err++;
        $display("FAIL gaps_pair_reg: mac_a=%0d mac_b=%0d required %0d %0d",
                 mac_a, mac_b, pa[i], pb[i]);
      end
      if (i < 2) begin
        for (int g = 0; g < 2; g++) begin
          @(negedge clk);
          n_cmp++;
          if (mac_a !== '0 || mac_b !== '0) begin
            n_err++;
            $display("FAIL gaps_zero: mac_a=%0d mac_b=%0d required 0 0", mac_a, mac_b);
          end
        end
      end
    end
    get_result(0, r, s, vc, clr);
    n_cmp++;
    if (r !== 16'd27 || s !== 1'b0) begin
      n_err++;
      $display("FAIL gaps_result: res=%0d sat=%0b required res=27 sat=0", r, s);
    end
  endtask

  task automatic test_overflow();
    int hs, vc;
    logic [OUT_W-1:0] r, er;
    logic s, es, clr;
`ifdef MAC_SEQ_SAT_EN
    er = 16'd32767; es = 1'b1;
`else
    er = 16'hBD03;  es = 1'b0;
`endif
    start_job(3);
    repeat (3) send_pair(127, 127, hs);
    get_result(0, r, s, vc, clr);
    n_cmp++;
    if (r !== er || s !== es) begin
      n_err++;
      $display("FAIL overflow_result: res=%0h sat=%0b required res=%0h sat=%0b", r, s, er, es);
    end
  endtask

  task automatic test_backpressure();
    int hs, n;
    logic [OUT_W-1:0] r0;
    start_job(3);
    send_pair(1, 2, hs);
    send_pair(3, 4, hs);
    send_pair(5, 6, hs);
    n = 0;
    while (!res_vld && n < 50) begin
      @(negedge clk);
      n++;
    end
    r0 = res;
    n_cmp++;
    if (r0 !== 16'd44) begin
      n_err++;
      $display("FAIL bp_result: res=%0d required=44", r0);
    end
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin start = 1'b1; len = 8'd5; end
      if (i == 2) begin start = 1'b0; len = '0; end
      @(negedge clk);
      n_cmp++;
      if (res !== 16'd44 || sat !== 1'b0 || res_vld !== 1'b1 || busy !== 1'b1) begin
        n_err++;
        $display("FAIL bp_hold: res=%0d sat=%0b res_vld=%0b busy=%0b required 44 0 1 1",
                 res, sat, res_vld, busy);
      end
    end
    res_rdy = 1'b1;
    @(negedge clk);
    res_rdy = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || res_vld !== 1'b0) begin
      n_err++;
      $display("FAIL bp_release: busy=%0b res_vld=%0b required 0 0", busy, res_vld);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || op_rdy !== 1'b0) begin
      n_err++;
      $display("FAIL bp_start_ignored: busy=%0b op_rdy=%0b required 0 0", busy, op_rdy);
    end
  endtask

  task automatic test_zero_len();
    int hs, vc;
    logic [OUT_W-1:0] r;
    logic s, clr;
    start_job(0);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (busy !== 1'b0 || res_vld !== 1'b0 || op_rdy !== 1'b0) begin
        n_err++;
        $display("FAIL zero_len_idle: busy=%0b res_vld=%0b op_rdy=%0b required 0 0 0",
                 busy, res_vld, op_rdy);
      end
      @(negedge clk);
    end
    start_job(1);
    send_pair(200, 1, hs);
    get_result(0, r, s, vc, clr);
    n_cmp++;
    if (r !== 16'd200 || s !== 1'b0) begin
      n_err++;
      $display("FAIL zero_len_next: res=%0d sat=%0b required res=200 sat=0", r, s);
    end
  endtask

  task automatic test_reset_mid_job();
    int hs, vc;
    logic [OUT_W-1:0] r;
    logic s, clr;
    start_job(4);
    send_pair(10, 10, hs);
    send_pair(20, 20, hs);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, op_rdy, mac_clr_n, res_vld, sat} !== 5'b0 || mac_a !== '0 ||
        mac_b !== '0 || res !== '0) begin
      n_err++;
      $display("FAIL reset_mid_job: busy=%0b op_rdy=%0b clr_n=%0b res_vld=%0b sat=%0b mac_a=%0d mac_b=%0d res=%0d required all 0",
               busy, op_rdy, mac_clr_n, res_vld, sat, mac_a, mac_b, res);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_job(1);
    send_pair(3, 3, hs);
    get_result(0, r, s, vc, clr);
    n_cmp++;
    if (r !== 16'd9 || s !== 1'b0) begin
      n_err++;
      $display("FAIL reset_next_job: res=%0d sat=%0b required res=9 sat=0", r, s);
    end
  endtask

  task automatic test_back_to_back();
    logic [OUT_W-1:0] r, e;
    logic s, es;
    for (int j = 0; j < 2; j++) begin
      run_job(2, 1'b0, 0, 0, r, s);
      e  = exp_q.pop_front();
      es = exp_sat_q.pop_front();
      n_cmp++;
      if (r !== e || s !== es) begin
        n_err++;
        $display("FAIL back_to_back_%0d: res=%0h sat=%0b required res=%0h sat=%0b", j, r, s, e, es);
      end
    end
  endtask

  task automatic test_random();
    logic [OUT_W-1:0] r, e;
    logic s, es;
    for (int j = 0; j < 12; j++) begin
      run_job($urandom_range(1, 12), 1'($urandom_range(0, 1)), 2, $urandom_range(0, 3), r, s);
      e  = exp_q.pop_front();
      es = exp_sat_q.pop_front();
      n_cmp++;
      if (r !== e || s !== es) begin
        n_err++;
        $display("FAIL random_job_%0d: res=%0h sat=%0b required res=%0h sat=%0b", j, r, s, e, es);
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_overflow();
    test_backpressure();
    test_zero_len();
    test_reset_mid_job();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: sim_time=%0t required completion before limit", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
